// File: rtl/pwm_reg_bank.sv
// PWM register bank: shadow duty/enable registers written over the register
// port, copied to the active registers either immediately or at the next PWM
// period boundary, under control of a small commit state machine.
//
// Register port handshake: a write is a single-cycle writeEn strobe with addr
// and dataIn valid in the same cycle; there is no backpressure. Every cycle is
// also an implicit read of addr, answered on dataOut one cycle later.
module pwm_reg_bank #(
   parameter int NUM_CH = 4,
   parameter int DUTY_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            addr,
   input  logic [7:0]            dataIn,
   input  logic                  writeEn,
   output logic [7:0]            dataOut,
   input  logic                  periodEnd,
   output logic [NUM_CH*8-1:0]   dutyActive,
   output logic [NUM_CH-1:0]     chEnActive,
   output logic                  updated,
   output logic [1:0]            stateDbg
);

   // Elaboration-time parameter checks
   generate
      if (DUTY_W != 8) begin : g_bad_duty_w
         $error("pwm_reg_bank: DUTY_W must be 8");
      end
      if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
         $error("pwm_reg_bank: NUM_CH must be in 1..8");
      end
   endgenerate

   localparam logic [7:0] ADDR_CTRL   = 8'h00;
   localparam logic [7:0] ADDR_STATUS = 8'h01;
   localparam logic [7:0] ADDR_ID     = 8'h02;
   localparam logic [7:0] ADDR_EN_SH  = 8'h03;
   localparam logic [3:0] CH_COUNT    = 4'(NUM_CH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      COPY    = 2'd2
   } commitState_t;

   commitState_t state;
   commitState_t nextState;

   logic                  ctrlLock;
   logic                  ctrlImm;
   logic                  overrun;
   logic [NUM_CH-1:0]     enSh;
   logic [NUM_CH*8-1:0]   dutySh;

   logic                  ctrlWr;
   logic                  statusWr;
   logic                  commitWr;
   logic                  shadowWrOk;
   logic                  copyNow;
   logic                  pendingFlag;
   logic                  overrunSet;
   logic [7:0]            readData;

   // Write strobes decoded from the register port
   always_comb begin
      ctrlWr     = writeEn && (addr == ADDR_CTRL);
      statusWr   = writeEn && (addr == ADDR_STATUS);
      commitWr   = ctrlWr && dataIn[0];
      shadowWrOk = writeEn && !ctrlLock;
   end

   // Commit FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Commit FSM: next state; periodEnd only matters while PENDING
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (commitWr) begin
               nextState = dataIn[2] ? COPY : PENDING;
            end
         end
         PENDING: begin
            if (periodEnd) begin
               nextState = COPY;
            end
         end
         COPY: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Commit FSM: decoded outputs
   always_comb begin
      copyNow     = (state == COPY);
      pendingFlag = (state != IDLE);
      overrunSet  = commitWr && (state != IDLE);
      stateDbg    = state;
   end

   // CTRL and STATUS; an OVERRUN set beats a simultaneous W1C clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrlLock <= 1'b0;
         ctrlImm  <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (ctrlWr) begin
            ctrlLock <= dataIn[1];
            ctrlImm  <= dataIn[2];
         end
         if (overrunSet) begin
            overrun <= 1'b1;
         end else if (statusWr && dataIn[1]) begin
            overrun <= 1'b0;
         end
      end
   end

   // Shadow registers, frozen while LOCK is set
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enSh   <= '0;
         dutySh <= '0;
      end else begin
         if (shadowWrOk && (addr == ADDR_EN_SH)) begin
            enSh <= dataIn[NUM_CH-1:0];
         end
         for (int n = 0; n < NUM_CH; n++) begin
            if (shadowWrOk && (addr == 8'(16 + n))) begin
               dutySh[8*n +: 8] <= dataIn;
            end
         end
      end
   end

   // Active registers: copied from the pre-edge shadow values in COPY
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dutyActive <= '0;
         chEnActive <= '0;
         updated    <= 1'b0;
      end else begin
         updated <= copyNow;
         if (copyNow) begin
            dutyActive <= dutySh;
            chEnActive <= enSh;
         end
      end
   end

   // Read mux; unmapped addresses and out-of-range channels read zero
   always_comb begin
      readData = 8'h00;
      case (addr)
         ADDR_CTRL:   readData = {5'b0, ctrlImm, ctrlLock, 1'b0};
         ADDR_STATUS: readData = {6'b0, overrun, pendingFlag};
         ADDR_ID:     readData = {4'hA, CH_COUNT};
         ADDR_EN_SH:  readData[NUM_CH-1:0] = enSh;
         default: begin
            for (int n = 0; n < NUM_CH; n++) begin
               if (addr == 8'(16 + n)) begin
                  readData = dutySh[8*n +: 8];
               end
               if (addr == 8'(32 + n)) begin
                  readData = dutyActive[8*n +: 8];
               end
            end
         end
      endcase
   end

   // Registered read data, one cycle after the address is sampled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dataOut <= 8'h00;
      end else begin
         dataOut <= readData;
      end
   end

endmodule

// File: doc/pwm_reg_bank.md
PWM_REG_BANK -- requirements
Module: pwm_reg_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of PWM channels; legal range 1..8.
REQ-002 Parameter DUTY_W, default 8, duty register width; legal 8 only in this revision; other values are rejected at elaboration.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 addr  input  8  register address from the I2C slave.
REQ-006 dataIn  input  8  write data.
REQ-007 writeEn  input  1  one-cycle write strobe.
REQ-008 dataOut  output  8  registered read data.
REQ-009 periodEnd  input  1  one-cycle pulse from the PWM generator marking a period boundary.
REQ-010 dutyActive  output  NUM_CH*8  active duty values; channel n occupies bits [8n+7:8n].
REQ-011 chEnActive  output  NUM_CH  active channel-enable mask.
REQ-012 updated  output  1  one-cycle pulse when shadow values are copied to the active registers.

Function
REQ-013 Register map:
- 0x00 CTRL rw: bit0 COMMIT (write-1 action, reads 0); bit1 LOCK; bit2 IMM; bits7:3 read 0.
- 0x01 STATUS: bit0 PENDING (ro); bit1 OVERRUN (sticky, write-1-to-clear).
- 0x02 ID ro: {4'hA, NUM_CH[3:0]}.
- 0x03 EN_SH rw: shadow enable mask; bits at NUM_CH and above read 0.
- 0x10+n DUTY_SH[n] rw.
- 0x20+n DUTY_ACT[n] ro.
REQ-014 All other addresses, including channel offsets >= NUM_CH, read 8'h00; writes to them are ignored.
REQ-015 Read latency is exactly one cycle: dataOut in cycle t+1 reflects register contents and addr at edge t; reads have no side effects.
REQ-016 A write takes effect at the clock edge where writeEn=1; a read of the same address on the next cycle returns the new value.
REQ-017 When LOCK=1, writes to EN_SH and DUTY_SH are ignored; CTRL and STATUS remain writable.
REQ-018 The commit state machine has three states: IDLE, PENDING and COPY.
REQ-019 In IDLE, a CTRL write with bit0=1 moves to COPY if the same write sets bit2=1 (new IMM value), else to PENDING.
REQ-020 In PENDING, periodEnd=1 moves to COPY; otherwise it stays in PENDING.
REQ-021 In COPY, the block copies all DUTY_SH to DUTY_ACT and EN_SH to chEnActive on that edge, pulses updated=1 for exactly that cycle, and returns to IDLE.
REQ-022 COPY samples the shadow values held before the edge; a shadow write in the same cycle lands in shadow only.
REQ-023 periodEnd in IDLE or COPY is ignored; a commit write coinciding with periodEnd in IDLE goes to PENDING and does not consume that periodEnd.
REQ-024 A COMMIT write while in PENDING or COPY sets OVERRUN and does not change the state.
REQ-025 If an OVERRUN set and a W1C clear of OVERRUN occur in the same cycle, set wins.
REQ-026 PENDING reads 1 exactly while the state is PENDING or COPY.
REQ-027 Commit latency:
- IMM=1: updated rises on the edge after the commit write edge.
- IMM=0: updated rises on the edge after the first periodEnd sampled in PENDING.
REQ-028 dutyActive and chEnActive change only in COPY and on reset.

Reset
REQ-029 While rst=1 the block asynchronously forces:
- state IDLE;
- CTRL=0, OVERRUN=0, EN_SH=0;
- all DUTY_SH=0, all DUTY_ACT=0, chEnActive=0;
- dataOut=8'h00, updated=0.
REQ-030 A reset asserted in PENDING or COPY aborts the commit with no copy and no updated pulse; after release the block accepts a new commit normally.

Verification
REQ-031 NUM_CH=4, reset, then read 0x02 -> 8'hA4; read 0x10 -> 8'h00; read 0x24 -> 8'h00.
REQ-032 Write 0x11=8'h80, EN_SH=4'hF, CTRL=8'h05 (IMM commit) -> one cycle later updated=1, dutyActive[15:8]=8'h80, chEnActive=4'hF; read 0x21 -> 8'h80.
REQ-033 Write 0x10=8'h40, CTRL=8'h01; hold periodEnd low for 10 cycles -> STATUS=8'h01, dutyActive[7:0] unchanged; pulse periodEnd -> next edge updated=1, dutyActive[7:0]=8'h40, then STATUS=8'h00.
REQ-034 While PENDING, write CTRL=8'h01 again -> STATUS=8'h03; write STATUS=8'h02 -> STATUS=8'h01; a second commit is not queued.
REQ-035 Set CTRL=8'h02 (LOCK), write 0x12=8'h55 -> 0x12 reads old value; clear LOCK, write 0x12=8'h55 -> 0x12 reads 8'h55.
REQ-036 Commit with IMM=0, assert rst mid-PENDING, then pulse periodEnd -> no updated pulse, all outputs 0.
